// File: rtl/xosera_bus_initiator_if.sv
// Request/response handshake and Xosera byte-bus pins for xosera_bus_initiator.
// The slave modport is the initiator's view; the master modport is the host/target side.
interface xosera_bus_initiator_if;
   logic        req_valid_i;
   logic        req_ready_o;
   logic        req_rd_i;
   logic [3:0]  req_reg_num_i;
   logic [1:0]  req_bytemask_i;
   logic [15:0] req_data_i;
   logic        rsp_valid_o;
   logic [15:0] rsp_data_o;
   logic        rsp_timeout_o;
   logic        bus_cs_n_o;
   logic        bus_rd_nwr_o;
   logic [3:0]  bus_reg_num_o;
   logic        bus_bytesel_o;
   logic [7:0]  bus_data_o;
   logic        bus_data_oe_o;
   logic [7:0]  bus_data_i;
   logic        bus_ack_i;

   modport slave (
      input  req_valid_i, req_rd_i, req_reg_num_i, req_bytemask_i, req_data_i,
      output req_ready_o, rsp_valid_o, rsp_data_o, rsp_timeout_o,
      output bus_cs_n_o, bus_rd_nwr_o, bus_reg_num_o, bus_bytesel_o, bus_data_o, bus_data_oe_o,
      input  bus_data_i, bus_ack_i
   );

   modport master (
      output req_valid_i, req_rd_i, req_reg_num_i, req_bytemask_i, req_data_i,
      input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_timeout_o,
      input  bus_cs_n_o, bus_rd_nwr_o, bus_reg_num_o, bus_bytesel_o, bus_data_o, bus_data_oe_o,
      output bus_data_i, bus_ack_i
   );
endinterface

// File: rtl/xosera_bus_initiator.sv
// Turns 16-bit register requests into strobed byte cycles on the Xosera 8-bit register bus.
// Define XOSERA_BUS_ACK_EN to stretch STROBE until bus_ack_i, with an ACK_TIMEOUT abort.
//
// state  | meaning
// IDLE   | ready for a request
// SETUP  | address/direction/data driven, CS high
// STROBE | CS low for the current byte
// HOLD   | CS high, address/data held
// RESP   | one-cycle completion pulse
module xosera_bus_initiator #(
   parameter int SETUP_CYCLES = 1,
   parameter int CS_CYCLES    = 4,
   parameter int HOLD_CYCLES  = 1,
   parameter int ACK_TIMEOUT  = 15
) (
   input  logic                   clk,
   input  logic                   reset_n_i,
   xosera_bus_initiator_if.slave  xif
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_SETUP  = 3'd1;
   localparam logic [2:0] ST_STROBE = 3'd2;
   localparam logic [2:0] ST_HOLD   = 3'd3;
   localparam logic [2:0] ST_RESP   = 3'd4;

   localparam int MAX_SC  = (SETUP_CYCLES > CS_CYCLES) ? SETUP_CYCLES : CS_CYCLES;
   localparam int MAX_SCH = (MAX_SC > HOLD_CYCLES) ? MAX_SC : HOLD_CYCLES;
   localparam int MAX_ALL = (MAX_SCH > ACK_TIMEOUT) ? MAX_SCH : ACK_TIMEOUT;
   localparam int CW      = $clog2(MAX_ALL + 2);

   localparam logic [CW-1:0] LD_SETUP = CW'(SETUP_CYCLES - 1);
   localparam logic [CW-1:0] LD_CS    = CW'(CS_CYCLES - 1);
   localparam logic [CW-1:0] LD_HOLD  = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] ONE      = CW'(1);

   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          sel_q, sel_d;
   logic          rd_q, rd_d;
   logic [3:0]    reg_q, reg_d;
   logic [1:0]    mask_q, mask_d;
   logic [15:0]   data_q, data_d;
   logic [15:0]   rsp_data_q, rsp_data_d;
   logic          tmo_q, tmo_d;
   logic          cs_n_q, cs_n_d;
   logic          oe_q, oe_d;
   logic          rd_nwr_q, rd_nwr_d;
   logic [3:0]    bus_reg_q, bus_reg_d;
   logic          bus_sel_q, bus_sel_d;
   logic [7:0]    bus_dat_q, bus_dat_d;
   logic          strobe_done, strobe_tmo;
`ifdef XOSERA_BUS_ACK_EN
   localparam logic [CW-1:0] LD_ACK = CW'(ACK_TIMEOUT - 1);
   logic          ext_q, ext_d;
   logic          ack_seen_q, ack_seen_d;
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sel_d       = sel_q;
      rd_d        = rd_q;
      reg_d       = reg_q;
      mask_d      = mask_q;
      data_d      = data_q;
      rsp_data_d  = rsp_data_q;
      tmo_d       = tmo_q;
      strobe_done = 1'b0;
      strobe_tmo  = 1'b0;
`ifdef XOSERA_BUS_ACK_EN
      ext_d       = ext_q;
      ack_seen_d  = ack_seen_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (xif.req_valid_i) begin
               rd_d       = xif.req_rd_i;
               reg_d      = xif.req_reg_num_i;
               mask_d     = xif.req_bytemask_i;
               data_d     = xif.req_data_i;
               rsp_data_d = 16'h0000;
               tmo_d      = 1'b0;
               if (xif.req_bytemask_i == 2'b00) begin
                  state_d = ST_RESP;
               end else begin
                  state_d = ST_SETUP;
                  sel_d   = !xif.req_bytemask_i[1];
                  cnt_d   = LD_SETUP;
               end
            end
         end
         ST_SETUP: begin
            if (cnt_q == '0) begin
               state_d = ST_STROBE;
               cnt_d   = LD_CS;
`ifdef XOSERA_BUS_ACK_EN
               ext_d      = 1'b0;
               ack_seen_d = 1'b0;
`endif
            end else begin
               cnt_d = cnt_q - ONE;
            end
         end
         ST_STROBE: begin
`ifdef XOSERA_BUS_ACK_EN
            // an ack seen anywhere in the minimum window ends STROBE right at CS_CYCLES
            if (!ext_q) begin
               ack_seen_d = ack_seen_q | xif.bus_ack_i;
               if (cnt_q == '0) begin
                  if (ack_seen_q | xif.bus_ack_i) begin
                     strobe_done = 1'b1;
                  end else if (ACK_TIMEOUT == 0) begin
                     strobe_tmo = 1'b1;
                  end else begin
                     ext_d = 1'b1;
                     cnt_d = LD_ACK;
                  end
               end else begin
                  cnt_d = cnt_q - ONE;
               end
            end else if (xif.bus_ack_i) begin
               strobe_done = 1'b1;
            end else if (cnt_q == '0) begin
               strobe_tmo = 1'b1;
            end else begin
               cnt_d = cnt_q - ONE;
            end
`else
            if (cnt_q == '0) strobe_done = 1'b1;
            else             cnt_d = cnt_q - ONE;
`endif
            if (strobe_done | strobe_tmo) begin
               state_d = ST_HOLD;
               cnt_d   = LD_HOLD;
            end
            if (strobe_done && rd_q) begin
               if (sel_q) rsp_data_d[7:0]  = xif.bus_data_i;
               else       rsp_data_d[15:8] = xif.bus_data_i;
            end
            if (strobe_tmo) tmo_d = 1'b1;
         end
         ST_HOLD: begin
            if (cnt_q == '0) begin
               if (!sel_q && mask_q[0] && !tmo_q) begin
                  state_d = ST_SETUP;
                  sel_d   = 1'b1;
                  cnt_d   = LD_SETUP;
               end else begin
                  state_d = ST_RESP;
               end
            end else begin
               cnt_d = cnt_q - ONE;
            end
         end
         ST_RESP:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      // pin values are registered from the next state so they never glitch
      cs_n_d    = (state_d != ST_STROBE);
      oe_d      = ((state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD)) && !rd_d;
      rd_nwr_d  = rd_nwr_q;
      bus_reg_d = bus_reg_q;
      bus_sel_d = bus_sel_q;
      bus_dat_d = bus_dat_q;
      if ((state_d == ST_SETUP) && (state_q != ST_SETUP)) begin
         rd_nwr_d  = rd_d;
         bus_reg_d = reg_d;
         bus_sel_d = sel_d;
         bus_dat_d = sel_d ? data_d[7:0] : data_d[15:8];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n_i) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         sel_q      <= 1'b0;
         rd_q       <= 1'b0;
         reg_q      <= 4'h0;
         mask_q     <= 2'b00;
         data_q     <= 16'h0000;
         rsp_data_q <= 16'h0000;
         tmo_q      <= 1'b0;
         cs_n_q     <= 1'b1;
         oe_q       <= 1'b0;
         rd_nwr_q   <= 1'b1;
         bus_reg_q  <= 4'h0;
         bus_sel_q  <= 1'b0;
         bus_dat_q  <= 8'h00;
`ifdef XOSERA_BUS_ACK_EN
         ext_q      <= 1'b0;
         ack_seen_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sel_q      <= sel_d;
         rd_q       <= rd_d;
         reg_q      <= reg_d;
         mask_q     <= mask_d;
         data_q     <= data_d;
         rsp_data_q <= rsp_data_d;
         tmo_q      <= tmo_d;
         cs_n_q     <= cs_n_d;
         oe_q       <= oe_d;
         rd_nwr_q   <= rd_nwr_d;
         bus_reg_q  <= bus_reg_d;
         bus_sel_q  <= bus_sel_d;
         bus_dat_q  <= bus_dat_d;
`ifdef XOSERA_BUS_ACK_EN
         ext_q      <= ext_d;
         ack_seen_q <= ack_seen_d;
`endif
      end
   end

   assign xif.req_ready_o   = (state_q == ST_IDLE);
   assign xif.rsp_valid_o   = (state_q == ST_RESP);
   assign xif.rsp_data_o    = rsp_data_q;
   assign xif.bus_cs_n_o    = cs_n_q;
   assign xif.bus_rd_nwr_o  = rd_nwr_q;
   assign xif.bus_reg_num_o = bus_reg_q;
   assign xif.bus_bytesel_o = bus_sel_q;
   assign xif.bus_data_o    = bus_dat_q;
   assign xif.bus_data_oe_o = oe_q;
`ifdef XOSERA_BUS_ACK_EN
   assign xif.rsp_timeout_o = tmo_q;
`else
   assign xif.rsp_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_xosera_bus_initiator.sv
// Bench for xosera_bus_initiator: timeline model of each request checked every cycle,
// plus directed cases with hand-computed values.
module tb_xosera_bus_initiator;
   localparam int S = 1;
   localparam int C = 4;
   localparam int H = 1;
   localparam int T = 15;
   localparam int P = S + C + H;

   logic clk;
   logic rst_n;
   logic [7:0] tgt_hi, tgt_lo;
   int   ack_mode;
   int   cur_low;
   int   edge_cnt;
   int   n_cmp, n_bad;
   bit   chk_en;

   xosera_bus_initiator_if ifc();

   xosera_bus_initiator #(
      .SETUP_CYCLES(S), .CS_CYCLES(C), .HOLD_CYCLES(H), .ACK_TIMEOUT(T)
   ) dut (
      .clk       (clk),
      .reset_n_i (rst_n),
      .xif       (ifc)
   );

   // target model: returns a fixed byte per byte lane
   assign ifc.bus_data_i = ifc.bus_bytesel_o ? tgt_lo : tgt_hi;
   assign ifc.bus_ack_i  = (ack_mode == 0) ? !ifc.bus_cs_n_o :
                           (ack_mode == 1) ? (!ifc.bus_cs_n_o && cur_low == 6) : 1'b0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // CS pulse log
   int  p_len[$];
   int  p_sel[$];
   int  p_dat[$];
   int  p_oe[$];
   int  p_gap[$];
   int  gap;
   bit  in_pulse, had_pulse;
   int  rsp_cnt;

   always @(negedge clk) begin
      if (ifc.rsp_valid_o) rsp_cnt++;
      if (!ifc.bus_cs_n_o) begin
         cur_low++;
         if (!in_pulse) begin
            if (had_pulse) p_gap.push_back(gap);
            p_len.push_back(0);
            p_sel.push_back(int'(ifc.bus_bytesel_o));
            p_dat.push_back(int'(ifc.bus_data_o));
            p_oe.push_back(int'(ifc.bus_data_oe_o));
            in_pulse  = 1'b1;
            had_pulse = 1'b1;
         end
         p_len[p_len.size()-1]++;
      end else begin
         cur_low = 0;
         if (in_pulse) begin
            in_pulse = 1'b0;
            gap = 0;
         end
         gap++;
      end
   end

   task automatic clear_log();
      p_len.delete(); p_sel.delete(); p_dat.delete(); p_oe.delete(); p_gap.delete();
      had_pulse = 1'b0;
      gap = 0;
   endtask

   // behavioural model: per-request timeline indexed by edges since the accept edge
   bit          m_busy;
   int          m_acc, m_n;
   logic        m_rd;
   logic [3:0]  m_reg;
   logic [1:0]  m_mask;
   logic [15:0] m_data, m_rsp, m_last;
   int          mk, mb, mo, msel;
   bit          m_idle_now;

   always @(negedge clk) begin
      if (chk_en) begin
         m_idle_now = !m_busy;
         if (m_busy) begin
            mk = edge_cnt - m_acc;
            chk("ready_busy", int'(ifc.req_ready_o), 0);
            chk("rsp_valid", int'(ifc.rsp_valid_o), int'(mk == m_n * P));
            if (mk < m_n * P) begin
               mb   = mk / P;
               mo   = mk % P;
               msel = (m_n == 2) ? mb : int'(m_mask[0]);
               chk("cs_n", int'(ifc.bus_cs_n_o), (mo >= S && mo < S + C) ? 0 : 1);
               chk("data_oe", int'(ifc.bus_data_oe_o), int'(!m_rd));
               chk("rd_nwr", int'(ifc.bus_rd_nwr_o), int'(m_rd));
               chk("reg_num", int'(ifc.bus_reg_num_o), int'(m_reg));
               chk("bytesel", int'(ifc.bus_bytesel_o), msel);
               if (!m_rd) chk("bus_data", int'(ifc.bus_data_o),
                              msel != 0 ? int'(m_data[7:0]) : int'(m_data[15:8]));
            end else begin
               chk("cs_n_resp", int'(ifc.bus_cs_n_o), 1);
               chk("oe_resp", int'(ifc.bus_data_oe_o), 0);
               chk("rsp_data", int'(ifc.rsp_data_o), int'(m_rsp));
               chk("rsp_timeout", int'(ifc.rsp_timeout_o), 0);
               m_busy = 1'b0;
               m_last = m_rsp;
            end
         end else begin
            chk("ready_idle", int'(ifc.req_ready_o), 1);
            chk("rsp_valid_idle", int'(ifc.rsp_valid_o), 0);
            chk("cs_n_idle", int'(ifc.bus_cs_n_o), 1);
            chk("oe_idle", int'(ifc.bus_data_oe_o), 0);
            chk("rsp_data_idle", int'(ifc.rsp_data_o), int'(m_last));
            chk("timeout_idle", int'(ifc.rsp_timeout_o), 0);
         end
         if (!rst_n) begin
            m_busy = 1'b0;
            m_last = 16'h0000;
         end else if (m_idle_now && ifc.req_valid_i) begin
            m_busy = 1'b1;
            m_acc  = edge_cnt + 1;
            m_rd   = ifc.req_rd_i;
            m_reg  = ifc.req_reg_num_i;
            m_mask = ifc.req_bytemask_i;
            m_data = ifc.req_data_i;
            m_n    = int'(m_mask[1]) + int'(m_mask[0]);
            m_rsp  = m_rd ? {m_mask[1] ? tgt_hi : 8'h00, m_mask[0] ? tgt_lo : 8'h00} : 16'h0000;
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // call at posedge+1; returns at posedge+1
   task automatic do_req(input logic rd, input logic [3:0] rn, input logic [1:0] mk_i,
                         input logic [15:0] dt, input logic [7:0] hi, input logic [7:0] lo,
                         input bit wait_rsp, output int lat, output logic [15:0] rdat,
                         output logic rto);
      bit got;
      int acc;
      ifc.req_rd_i       = rd;
      ifc.req_reg_num_i  = rn;
      ifc.req_bytemask_i = mk_i;
      ifc.req_data_i     = dt;
      tgt_hi             = hi;
      tgt_lo             = lo;
      ifc.req_valid_i    = 1'b1;
      lat  = -1;
      rdat = 16'h0000;
      rto  = 1'b0;
      acc  = 0;
      got  = 1'b0;
      for (int t = 0; t < 200 && !got; t++) begin
         @(negedge clk);
         if (ifc.req_ready_o) got = 1'b1;
      end
      if (!got) chk("accept_wait", 0, 1);
      acc = edge_cnt + 1;
      @(posedge clk);
      #1;
      ifc.req_valid_i = 1'b0;
      if (wait_rsp) begin
         got = 1'b0;
         for (int t = 0; t < 200 && !got; t++) begin
            @(negedge clk);
            if (ifc.rsp_valid_o) begin
               got  = 1'b1;
               lat  = edge_cnt - acc;
               rdat = ifc.rsp_data_o;
               rto  = ifc.rsp_timeout_o;
            end
         end
         if (!got) chk("rsp_wait", 0, 1);
         @(posedge clk);
         #1;
      end
   endtask

   int          lat;
   logic [15:0] rdat;
   logic        rto;
   int          r0;

   initial begin
      n_cmp = 0; n_bad = 0; edge_cnt = 0; rsp_cnt = 0; cur_low = 0; gap = 0;
      ack_mode = 0; chk_en = 1'b0; m_busy = 1'b0; m_last = 16'h0000;
      in_pulse = 1'b0; had_pulse = 1'b0;
      tgt_hi = 8'h00; tgt_lo = 8'h00;
      ifc.req_valid_i = 1'b0; ifc.req_rd_i = 1'b0; ifc.req_reg_num_i = 4'h0;
      ifc.req_bytemask_i = 2'b00; ifc.req_data_i = 16'h0000;
      rst_n = 1'b0;
      idle(3);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_cs_n", int'(ifc.bus_cs_n_o), 1);
      chk("rst_rd_nwr", int'(ifc.bus_rd_nwr_o), 1);
      chk("rst_oe", int'(ifc.bus_data_oe_o), 0);
      chk("rst_reg_num", int'(ifc.bus_reg_num_o), 0);
      chk("rst_bytesel", int'(ifc.bus_bytesel_o), 0);
      chk("rst_bus_data", int'(ifc.bus_data_o), 0);
      chk("rst_ready", int'(ifc.req_ready_o), 1);
      chk("rst_rsp_valid", int'(ifc.rsp_valid_o), 0);
      chk("rst_rsp_data", int'(ifc.rsp_data_o), 0);
      chk("rst_timeout", int'(ifc.rsp_timeout_o), 0);
      idle(1);
      chk_en = 1'b1;

      // 16-bit write
      clear_log();
      do_req(1'b0, 4'd3, 2'b11, 16'hA55A, 8'h00, 8'h00, 1'b1, lat, rdat, rto);
      chk("wr16_latency", lat, 12);
      chk("wr16_rsp_data", int'(rdat), 0);
      chk("wr16_pulses", p_len.size(), 2);
      if (p_len.size() == 2) begin
         chk("wr16_len0", p_len[0], 4);
         chk("wr16_sel0", p_sel[0], 0);
         chk("wr16_dat0", p_dat[0], 'hA5);
         chk("wr16_oe0", p_oe[0], 1);
         chk("wr16_len1", p_len[1], 4);
         chk("wr16_sel1", p_sel[1], 1);
         chk("wr16_dat1", p_dat[1], 'h5A);
      end

      // 16-bit read
      do_req(1'b1, 4'd7, 2'b11, 16'h0000, 8'h12, 8'h34, 1'b1, lat, rdat, rto);
      chk("rd16_rsp_data", int'(rdat), 'h1234);
      chk("rd16_latency", lat, 12);

      // odd byte only, then empty mask
      clear_log();
      do_req(1'b1, 4'd2, 2'b01, 16'h0000, 8'h99, 8'hEE, 1'b1, lat, rdat, rto);
      chk("rd8_rsp_data", int'(rdat), 'h00EE);
      chk("rd8_latency", lat, 6);
      chk("rd8_pulses", p_len.size(), 1);
      if (p_sel.size() == 1) chk("rd8_sel", p_sel[0], 1);
      clear_log();
      do_req(1'b1, 4'd5, 2'b00, 16'h0000, 8'h77, 8'h66, 1'b1, lat, rdat, rto);
      chk("mask0_latency", lat, 0);
      chk("mask0_rsp_data", int'(rdat), 0);
      chk("mask0_pulses", p_len.size(), 0);

      // reset during the second STROBE cycle
      r0 = rsp_cnt;
      do_req(1'b0, 4'd9, 2'b11, 16'hBEEF, 8'h00, 8'h00, 1'b0, lat, rdat, rto);
      for (int t = 0; t < 20 && ifc.bus_cs_n_o; t++) @(negedge clk);
      chk("rst_mid_cs_low", int'(ifc.bus_cs_n_o), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_mid_cs_high", int'(ifc.bus_cs_n_o), 1);
      chk("rst_mid_oe", int'(ifc.bus_data_oe_o), 0);
      idle(1);
      rst_n = 1'b1;
      idle(15);
      chk("rst_mid_no_rsp", rsp_cnt - r0, 0);
      chk("rst_mid_ready", int'(ifc.req_ready_o), 1);

      // back-to-back writes with valid held high
      clear_log();
      r0 = rsp_cnt;
      do_req(1'b0, 4'd1, 2'b11, 16'h1122, 8'h00, 8'h00, 1'b0, lat, rdat, rto);
      do_req(1'b0, 4'd2, 2'b11, 16'h3344, 8'h00, 8'h00, 1'b0, lat, rdat, rto);
      do_req(1'b0, 4'd3, 2'b11, 16'h5566, 8'h00, 8'h00, 1'b0, lat, rdat, rto);
      idle(30);
      chk("b2b_responses", rsp_cnt - r0, 3);
      chk("b2b_pulses", p_len.size(), 6);
      if (p_gap.size() == 5) begin
         chk("b2b_gap_in_req", p_gap[0], 2);
         chk("b2b_gap_between_1", p_gap[1], 4);
         chk("b2b_gap_between_2", p_gap[3], 4);
      end else chk("b2b_gap_count", p_gap.size(), 5);

      // randomized traffic
      for (int i = 0; i < 150; i++) begin
         logic        rd;
         bit          wr;
         rd = 1'($urandom_range(0, 1));
         wr = rd ? 1'b1 : ($urandom_range(0, 1) == 1);
         do_req(rd, 4'($urandom), 2'($urandom), 16'($urandom), 8'($urandom), 8'($urandom),
                wr, lat, rdat, rto);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
      end
      idle(40);

`ifdef XOSERA_BUS_ACK_EN
      chk_en = 1'b0;
      clear_log();
      ack_mode = 1;
      do_req(1'b0, 4'd4, 2'b11, 16'hC3C3, 8'h00, 8'h00, 1'b1, lat, rdat, rto);
      chk("ack6_pulses", p_len.size(), 2);
      if (p_len.size() > 0) chk("ack6_len", p_len[0], 6);
      chk("ack6_timeout", int'(rto), 0);
      clear_log();
      ack_mode = 2;
      do_req(1'b0, 4'd4, 2'b11, 16'hC3C3, 8'h00, 8'h00, 1'b1, lat, rdat, rto);
      chk("noack_pulses", p_len.size(), 1);
      if (p_len.size() > 0) chk("noack_len", p_len[0], C + T);
      if (p_sel.size() > 0) chk("noack_sel", p_sel[0], 0);
      chk("noack_timeout", int'(rto), 1);
      idle(3);
      chk("noack_timeout_held", int'(ifc.rsp_timeout_o), 1);
      ack_mode = 0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/xosera_bus_initiator.md
# xosera_bus_initiator

Host-side initiator for the Xosera 8-bit register bus. It turns 16-bit register read and write requests, sent over a valid/ready handshake, into the byte-wide strobed bus cycles that the Xosera register interface decodes. Each byte cycle uses `bus_cs_n`, `bus_rd_nwr`, `bus_reg_num`, `bus_bytesel` and `bus_data`. It sits between an on-FPGA host (bootstrap sequencer, test harness, soft CPU bridge) and the bus pins of `xosera_main`.

## Interface
Parameters:
- `SETUP_CYCLES`, default 1: cycles that address, direction and data are stable before CS falls. Must be ≥1.
- `CS_CYCLES`, default 4: minimum cycles CS is held low. Must be ≥1.
- `HOLD_CYCLES`, default 1: cycles that address and data are held after CS rises. Must be ≥1.
- `ACK_TIMEOUT`, default 15: extra cycles to wait for ack after `CS_CYCLES`. Used only when the ack feature is compiled in.

Ports:
- `clk` in 1: single clock domain for the whole block.
- `reset_n_i` in 1: reset, synchronous, active-low.
- `req_valid_i` in 1: request valid.
- `req_ready_o` out 1: block can accept a request.
- `req_rd_i` in 1: 1 = read, 0 = write.
- `req_reg_num_i` in 4: register number.
- `req_bytemask_i` in 2: bit1 = even/high byte, bit0 = odd/low byte.
- `req_data_i` in 16: write data.
- `rsp_valid_o` out 1: one-cycle completion pulse.
- `rsp_data_o` out 16: read data.
- `rsp_timeout_o` out 1: request aborted because no ack arrived.
- `bus_cs_n_o` out 1: chip select, active low.
- `bus_rd_nwr_o` out 1: 1 = read, 0 = write.
- `bus_reg_num_o` out 4: register number on the bus.
- `bus_bytesel_o` out 1: 0 = even byte, 1 = odd byte.
- `bus_data_o` out 8: write data byte.
- `bus_data_oe_o` out 1: data bus output enable.
- `bus_data_i` in 8: read data byte.
- `bus_ack_i` in 1: cycle acknowledge from the target.

## Operation
- **States:**
  - IDLE: `req_ready_o`=1 only in this state. On `req_valid_i & req_ready_o`, latch the request and go to SETUP for the first enabled byte.
  - SETUP: drive the byte and count `SETUP_CYCLES`, then go to STROBE.
  - STROBE: CS low, count `CS_CYCLES`, then go to HOLD.
  - HOLD: CS high, count `HOLD_CYCLES`. Then go to SETUP for the next enabled byte, or to RESP if none remain.
  - RESP: pulse `rsp_valid_o` for one cycle, then return to IDLE.
- **Byte order:** even byte first (`bus_bytesel_o`=0 carries data[15:8]), then odd byte (`bus_bytesel_o`=1 carries data[7:0]). Bytes whose mask bit is clear are skipped.
- **Empty mask:** `req_bytemask_i`=2'b00 goes from IDLE straight to RESP, with `rsp_data_o`=0 and no bus activity.
- **Stable outputs:** `bus_reg_num_o`, `bus_rd_nwr_o`, `bus_bytesel_o` and `bus_data_o` stay constant from SETUP through HOLD of each byte.
- **Write data drive:** `bus_data_oe_o`=1 during SETUP, STROBE and HOLD of writes only; it is 0 for reads and in IDLE/RESP.
- **Read capture:** `bus_data_i` is sampled on the last STROBE cycle, the edge on which CS rises. The even byte goes to `rsp_data_o[15:8]`, the odd byte to `[7:0]`. Skipped bytes read as 8'h00.
- **Response register:** `rsp_data_o` is cleared when a request is accepted and keeps its value after RESP until the next acceptance. For writes it stays 0.
- **Responses for every request:** reads and writes both get a `rsp_valid_o` pulse. The response has no backpressure.

## Timing
- **Reset values:**
  - `bus_cs_n_o`=1, `bus_rd_nwr_o`=1, `bus_data_oe_o`=0.
  - `bus_reg_num_o`=0, `bus_bytesel_o`=0, `bus_data_o`=0.
  - `req_ready_o`=1, `rsp_valid_o`=0, `rsp_data_o`=0, `rsp_timeout_o`=0.
  - State = IDLE.
- **Reset mid-operation:** at the next edge CS goes high, `bus_data_oe_o` goes to 0 and the state returns to IDLE. No response is emitted.
- **Latency:** a request with n enabled bytes (n ∈ {1,2}) gives `rsp_valid_o` n·(S+C+H) cycles after the accept edge, where S/C/H are `SETUP_CYCLES`/`CS_CYCLES`/`HOLD_CYCLES`. Defaults: 12 cycles for a 16-bit access, 6 for 8-bit.
- **Back-to-back requests:** `req_ready_o` rises the cycle after RESP. Consecutive bus cycles are therefore separated by at least `HOLD_CYCLES`+2 cycles of CS high.
- **Counters:** cycle counters are sized for max(S, C, H, `ACK_TIMEOUT`)+1 and must not wrap.

## Configuration
- **`XOSERA_BUS_ACK_EN` defined:**
  - STROBE lasts at least `CS_CYCLES`, then continues until `bus_ack_i` is sampled high. CS rises on the edge after ack is seen, and read data is captured on that edge.
  - If no ack arrives within `ACK_TIMEOUT` further cycles, the block goes to HOLD and skips any remaining byte. The response then carries `rsp_timeout_o`=1, which is held until the next accept.
  - An ack that is already high during the minimum window ends STROBE exactly at `CS_CYCLES`.
- **`XOSERA_BUS_ACK_EN` undefined:** `bus_ack_i` is ignored, `rsp_timeout_o` is tied to 0, and STROBE is exactly `CS_CYCLES` long.

## Test plan
- **16-bit write:** defaults, write reg 3, mask 2'b11, data 16'hA55A → two CS pulses, each 4 cycles low. First: bytesel=0, data 8'hA5, oe=1. Second: bytesel=1, data 8'h5A. `rsp_valid_o` 12 cycles after accept, `rsp_data_o`=0.
- **16-bit read:** read reg 7, mask 2'b11, model drives 8'h12 then 8'h34 → `rd_nwr`=1 and oe=0 throughout, `rsp_data_o`=16'h1234.
- **Partial masks:** mask 2'b01 read with model 8'hEE → single bytesel=1 cycle, `rsp_data_o`=16'h00EE, response after 6 cycles. Mask 2'b00 → no CS activity, `rsp_valid_o` on the cycle after accept.
- **Reset mid-STROBE:** `reset_n_i`=0 during the 2nd STROBE cycle → `bus_cs_n_o`=1 next edge, no `rsp_valid_o`, `req_ready_o`=1 after reset is released.
- **Ack timeout (`XOSERA_BUS_ACK_EN`):** with ack at STROBE cycle 6, CS is low 6 cycles and `rsp_timeout_o`=0. With ack never asserted, CS is low 4+15 cycles, only the even byte is issued, and `rsp_timeout_o`=1.
- **Back-to-back writes:** `req_valid_i` held high for 3 writes → `req_ready_o` low while busy, 3 responses in order, CS high ≥3 cycles between pulses.
